// File: rtl/shiftreg_input_scanner.sv
// Scans a chain of parallel-in/serial-out registers: latch, shift N_BITS bits, commit the frame.
// Optional frame debounce is enabled by defining SHIFTREG_SCANNER_DEBOUNCE_EN.
module shiftreg_input_scanner #(
    parameter int N_BITS         = 24,
    parameter int CLK_DIV        = 4,
    parameter int LATCH_TICKS    = 2,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_scan_en,
    input  logic              i_sr_data,
    output logic              o_sr_latch,
    output logic              o_sr_clk,
    output logic [N_BITS-1:0] o_data,
    output logic              o_valid,
    output logic              o_changed
);

    if (N_BITS < 1 || N_BITS > 64 || CLK_DIV < 1 || CLK_DIV > 65535 ||
        LATCH_TICKS < 1 || LATCH_TICKS > 255 ||
        DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : gBadParams
        $error("shiftreg_input_scanner: parameter out of range");
    end

    localparam int TickW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LatchW = $clog2(LATCH_TICKS + 1);
    localparam int BitW   = $clog2(N_BITS + 1);

    localparam logic [TickW-1:0]  TickLast  = TickW'(CLK_DIV - 1);
    localparam logic [LatchW-1:0] LatchLast = LatchW'(LATCH_TICKS - 1);
    localparam logic [BitW-1:0]   BitsAll   = BitW'(N_BITS);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SHIFT_HI,
        SHIFT_LO,
        DONE
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [TickW-1:0]  tickCnt;
    logic              tick;
    logic [LatchW-1:0] latchCnt;
    logic [BitW-1:0]   bitCnt;
    logic [N_BITS-1:0] shiftReg;
    logic [N_BITS-1:0] shiftNext;
    logic              frameDone;
    logic              commit;

    // Free-running tick divider; it never pauses, so frame timing is always phase-locked to reset.
    assign tick = (tickCnt == TickLast);

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tickCnt <= '0;
        end else if (tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + TickW'(1);
        end
    end

    // NOTE: nextState gets a default before the case so no latch is inferred.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:     if (tick && i_scan_en) nextState = LATCH;
            LATCH:    if (tick && latchCnt == LatchLast) nextState = SHIFT_HI;
            SHIFT_HI: if (tick) nextState = SHIFT_LO;
            SHIFT_LO: if (tick) nextState = (bitCnt == BitsAll) ? DONE : SHIFT_HI;
            DONE:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    if (N_BITS == 1) begin : gOneBit
        assign shiftNext = i_sr_data;
    end else begin : gManyBits
        assign shiftNext = {shiftReg[N_BITS-2:0], i_sr_data};
    end

    // Strobes are registered from nextState so the chain sees glitch-free edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_sr_latch <= 1'b1;
            o_sr_clk   <= 1'b0;
            latchCnt   <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
        end else begin
            state      <= nextState;
            o_sr_latch <= (nextState != LATCH);
            o_sr_clk   <= (nextState == SHIFT_LO);

            if (state == LATCH) begin
                if (tick) latchCnt <= latchCnt + LatchW'(1);
            end else begin
                latchCnt <= '0;
            end

            if (state == SHIFT_HI && tick) begin
                shiftReg <= shiftNext;
                bitCnt   <= bitCnt + BitW'(1);
            end else if (state == IDLE) begin
                bitCnt <= '0;
            end
        end
    end

    assign frameDone = (state == DONE);

`ifdef SHIFTREG_SCANNER_DEBOUNCE_EN
    localparam logic [3:0] DebMax = 4'(DEBOUNCE_SCANS);

    logic [N_BITS-1:0] prevFrame;
    logic [3:0]        stableCnt;
    logic [3:0]        stableNext;
    logic              sameFrame;

    // stableCnt of zero means no frame has been seen since reset.
    always_comb begin
        sameFrame  = (stableCnt != 4'd0) && (shiftReg == prevFrame);
        stableNext = 4'd1;
        if (sameFrame) stableNext = (stableCnt == DebMax) ? DebMax : stableCnt + 4'd1;
        commit = (stableNext == DebMax) &&
                 ((shiftReg != o_data) || (sameFrame && stableCnt == DebMax));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prevFrame <= '0;
            stableCnt <= '0;
        end else if (frameDone) begin
            prevFrame <= shiftReg;
            stableCnt <= stableNext;
        end
    end
`else
    assign commit = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_changed <= 1'b0;
        end else begin
            o_valid   <= frameDone && commit;
            o_changed <= frameDone && commit && (shiftReg != o_data);
            if (frameDone && commit) o_data <= shiftReg;
        end
    end

endmodule

// File: tb/tb_shiftreg_input_scanner.sv
// Bench for shiftreg_input_scanner: two configurations driven by behavioural PISO chain models,
// checked against a frame-level reference model (debounce rules follow SHIFTREG_SCANNER_DEBOUNCE_EN).
module tb_shiftreg_input_scanner;

    localparam int A_BITS = 8;
    localparam int A_DIV  = 2;
    localparam int A_LT   = 1;
    localparam int B_BITS = 24;
    localparam int B_DIV  = 1;
    localparam int B_LT   = 2;
    localparam int DEB    = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  scanEn;
    logic        srDataA, srDataB;
    logic        latchA, srClkA, validA, changedA;
    logic        latchB, srClkB, validB, changedB;
    logic [7:0]  dataA;
    logic [23:0] dataB;

    logic [7:0]  chainA;
    logic [23:0] chainB;
    logic [7:0]  qA[$];
    logic [23:0] qB[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shiftreg_input_scanner #(
        .N_BITS(A_BITS), .CLK_DIV(A_DIV), .LATCH_TICKS(A_LT), .DEBOUNCE_SCANS(DEB)
    ) dutA (
        .i_clk(clk), .i_rst_n(rstN), .i_scan_en(scanEn[0]), .i_sr_data(srDataA),
        .o_sr_latch(latchA), .o_sr_clk(srClkA), .o_data(dataA),
        .o_valid(validA), .o_changed(changedA)
    );

    shiftreg_input_scanner #(
        .N_BITS(B_BITS), .CLK_DIV(B_DIV), .LATCH_TICKS(B_LT), .DEBOUNCE_SCANS(DEB)
    ) dutB (
        .i_clk(clk), .i_rst_n(rstN), .i_scan_en(scanEn[1]), .i_sr_data(srDataB),
        .o_sr_latch(latchB), .o_sr_clk(srClkB), .o_data(dataB),
        .o_valid(validB), .o_changed(changedB)
    );

    // Chain models: parallel load on the latch falling edge, shift on each shift-clock rise.
    always @(negedge latchA or posedge srClkA) begin
        if (!latchA) chainA = (qA.size() > 0) ? qA.pop_front() : 8'h00;
        else         chainA = chainA << 1;
    end
    always @(negedge latchB or posedge srClkB) begin
        if (!latchB) chainB = (qB.size() > 0) ? qB.pop_front() : 24'h0;
        else         chainB = chainB << 1;
    end
    assign srDataA = chainA[7];
    assign srDataB = chainB[23];

    wire [1:0] latchV   = {latchB, latchA};
    wire [1:0] clkV     = {srClkB, srClkA};
    wire [1:0] validV   = {validB, validA};
    wire [1:0] changedV = {changedB, changedA};

    function automatic int nbits(input int u); return (u == 0) ? A_BITS : B_BITS; endfunction
    function automatic int div(input int u);   return (u == 0) ? A_DIV : B_DIV;   endfunction
    function automatic int lt(input int u);    return (u == 0) ? A_LT : B_LT;     endfunction
    function automatic logic [63:0] obsData(input int u);
        return (u == 0) ? 64'(dataA) : 64'(dataB);
    endfunction

    // Waveform monitor: edge counts and cycle stamps of the chain strobes.
    int         cyc = 0;
    int         latchFalls[2], latchFallCyc[2], curLow[2], lastLow[2];
    int         riseInFrame[2], badGap[2], rises[2], lastRiseCyc[2];
    int         falls[2], lastFallCyc[2], validCnt[2], changedCnt[2];
    logic [1:0] prevLatch = 2'b11;
    logic [1:0] prevClk   = 2'b00;

    always @(negedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (!latchV[u] && prevLatch[u]) begin
                latchFalls[u]++;
                latchFallCyc[u] = cyc;
                curLow[u] = 0;
            end
            if (!latchV[u]) curLow[u]++;
            if (latchV[u] && !prevLatch[u]) begin
                lastLow[u] = curLow[u];
                riseInFrame[u] = 0;
                badGap[u] = 0;
            end
            if (clkV[u] && !prevClk[u]) begin
                if (riseInFrame[u] > 0 && cyc - lastRiseCyc[u] != 2 * div(u)) badGap[u]++;
                riseInFrame[u]++;
                rises[u]++;
                lastRiseCyc[u] = cyc;
            end
            if (!clkV[u] && prevClk[u]) begin
                falls[u]++;
                lastFallCyc[u] = cyc;
            end
            if (validV[u] === 1'b1) validCnt[u]++;
            if (changedV[u] === 1'b1) changedCnt[u]++;
            prevLatch[u] = latchV[u];
            prevClk[u]   = clkV[u];
        end
    end

    // Frame-level reference: committed word plus length of the current run of identical frames.
    logic [63:0] mCommitted[2];
    logic [63:0] mLast[2];
    int          mRun[2];

    function automatic void modelReset();
        for (int u = 0; u < 2; u++) begin
            mCommitted[u] = '0;
            mLast[u] = '0;
            mRun[u] = 0;
        end
    endfunction

    task automatic modelStep(input int u, input logic [63:0] val,
                             output logic v, output logic c, output logic [63:0] d);
        mRun[u] = (mRun[u] > 0 && val == mLast[u]) ? mRun[u] + 1 : 1;
        mLast[u] = val;
`ifdef SHIFTREG_SCANNER_DEBOUNCE_EN
        v = ((mRun[u] == DEB) && (val != mCommitted[u])) || (mRun[u] > DEB);
`else
        v = 1'b1;
`endif
        c = v && (val != mCommitted[u]);
        if (v) mCommitted[u] = val;
        d = mCommitted[u];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input int u, input string tag);
        check({tag, " latch"},   64'(latchV[u]),   64'd1);
        check({tag, " srclk"},   64'(clkV[u]),     64'd0);
        check({tag, " data"},    obsData(u),       64'd0);
        check({tag, " valid"},   64'(validV[u]),   64'd0);
        check({tag, " changed"}, 64'(changedV[u]), 64'd0);
    endtask

    // Follows one frame from latch to commit; optionally drops scan enable after bit dropAt.
    task automatic runFrame(input int u, input logic [63:0] val, input int dropAt, input string tag);
        logic        expV, expC;
        logic [63:0] expD;
        int          f0, v0, c0, t;
        modelStep(u, val, expV, expC, expD);
        f0 = falls[u];
        v0 = validCnt[u];
        c0 = changedCnt[u];
        t  = 0;
        while (falls[u] < f0 + nbits(u) && t < 500) begin
            sample();
            t++;
            if (riseInFrame[u] == dropAt) scanEn[u] = 1'b0;
        end
        check({tag, " done"},     64'(t < 500), 64'd1);
        check({tag, " len"},      64'(lastFallCyc[u] - latchFallCyc[u]),
                                  64'((lt(u) + 2 * nbits(u)) * div(u)));
        check({tag, " latchlow"}, 64'(lastLow[u]), 64'(lt(u) * div(u)));
        check({tag, " clks"},     64'(riseInFrame[u]), 64'(nbits(u)));
        check({tag, " gap"},      64'(badGap[u]), 64'd0);
        sample();
        check({tag, " valid"},    64'(validV[u]), 64'(expV));
        check({tag, " changed"},  64'(changedV[u]), 64'(expC));
        check({tag, " data"},     obsData(u), expD);
        sample();
        check({tag, " pulse"},    64'(validCnt[u] - v0), 64'(expV));
        check({tag, " chgcnt"},   64'(changedCnt[u] - c0), 64'(expC));
    endtask

    initial begin
        logic [7:0]  seqA[15];
        logic [23:0] seqB[4];
        int          t, rel, lf, r, v;

        rstN   = 1'b0;
        scanEn = 2'b00;
        modelReset();
        sample();
        sample();
        checkResetOutputs(0, "rstA");
        checkResetOutputs(1, "rstB");

        seqA[0] = 8'hA5;
        seqA[1] = 8'hA5;
        seqA[2] = 8'h5A;
        for (int i = 3; i < 9; i++)
            seqA[i] = ($urandom_range(0, 2) == 0) ? seqA[i-1] : 8'($urandom);
        seqA[9]  = 8'h0F;
        seqA[10] = 8'h0F;
        seqA[11] = 8'hFF;
        seqA[12] = 8'h0F;
        seqA[13] = 8'h0F;
        seqA[14] = 8'h0F;
        for (int i = 0; i < 15; i++) qA.push_back(seqA[i]);

        scanEn[0] = 1'b1;
        rstN = 1'b1;
        rel = cyc;
        lf = latchFalls[0];
        t = 0;
        while (latchFalls[0] == lf && t < 50) begin
            sample();
            t++;
        end
        check("first tick latency", 64'(latchFallCyc[0] - rel), 64'(A_DIV));

        for (int i = 0; i < 15; i++)
            runFrame(0, 64'(seqA[i]), (i == 14) ? 4 : -1, $sformatf("A%0d", i));

        lf = latchFalls[0];
        r  = rises[0];
        repeat (40) sample();
        check("idle latch falls", 64'(latchFalls[0] - lf), 64'd0);
        check("idle srclk edges", 64'(rises[0] - r), 64'd0);
        check("idle latch level", 64'(latchA), 64'd1);

        qA.push_back(8'hC3);
        qA.push_back(8'h3C);
        scanEn[0] = 1'b1;
        t = 0;
        while (riseInFrame[0] != 5 && t < 200) begin
            sample();
            t++;
        end
        check("reset bit5 reached", 64'(t < 200), 64'd1);
        rstN = 1'b0;
        #1;
        checkResetOutputs(0, "midrst");
        modelReset();
        v = validCnt[0];
        sample();
        sample();
        rstN = 1'b1;
        check("midrst no commit", 64'(validCnt[0] - v), 64'd0);
        runFrame(0, 64'h3C, 4, "postrst");

        seqB[0] = 24'h123456;
        seqB[1] = 24'h123456;
        seqB[2] = 24'h123456;
        seqB[3] = 24'($urandom);
        for (int i = 0; i < 4; i++) qB.push_back(seqB[i]);
        scanEn[1] = 1'b1;
        for (int i = 0; i < 4; i++)
            runFrame(1, 64'(seqB[i]), (i == 3) ? 10 : -1, $sformatf("B%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
